muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Multi-cycle multiply/divide sequencer beside the EX-stage ALU. Accepts MULT/MULTU/DIV/DIVU
//  from EX, runs one radix-2 iteration per cycle and writes the HI/LO registers.
//  Drives a stall request to the hazard unit so no instruction issues past EX until HI/LO are final.
//  Also executes MTHI/MTLO and supplies HI/LO for MFHI/MFLO forwarding.
// PARAMETERS
//  WIDTH  32  operand width; an operation takes WIDTH iterations
// PORTS
//  clk       in   1      clock; all state updates on rising edge
//  rst_n     in   1      synchronous active-low reset
//  start     in   1      op valid from EX this cycle
//  op        in   3      0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 reserved (NOP)
//  a         in   WIDTH  forwarded rs value (multiplicand / dividend / MTHI-MTLO data)
//  b         in   WIDTH  forwarded rt value (multiplier / divisor)
//  flush     in   1      abort in-flight op (exception/overflow in EX)
//  hi        out  WIDTH  HI register
//  lo        out  WIDTH  LO register
//  busy      out  1      state==BUSY
//  stall     out  1      hold IF/ID/EX: (start & op in 1..4 & state==IDLE) | busy
//  done      out  1      1-cycle pulse, cycle after HI/LO written by a mul/div
//  div_zero  out  1      1-cycle pulse with done when divisor was 0
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, count=0, hi=lo=0, busy=stall=done=div_zero=0, scratch regs 0.
//  States: IDLE, BUSY. Counter count[$clog2(WIDTH):0].
//  IDLE:
//   - start & op 1..4: latch magnitudes (|a|,|b| when signed, raw when unsigned), result signs
//     (MULT: sa^sb; DIV: quotient sa^sb, remainder sa), count=0 -> BUSY. stall high this cycle.
//   - start & op 5/6: hi<=a / lo<=a next edge; stay IDLE; no stall, no done.
//   - op 0/7 or start=0: no effect.
//  BUSY, one iteration per cycle, count increments:
//   - MUL: shift-add on 2*WIDTH accumulator (LSB of multiplier selects add).
//   - DIV: restoring; shift remainder left, subtract divisor, keep if non-negative, quotient bit=~borrow.
//   - At the edge where count==WIDTH-1: apply sign correction (two's complement negate where sign=1).
//     MUL writes {hi,lo}=product; DIV writes lo=quotient, hi=remainder. -> IDLE.
//   - done=1 the following cycle. Total stall = 1 + WIDTH cycles (33 at default).
//   - start ignored while BUSY (stall guarantees EX holds).
//  Divide by zero (b==0 at accept): no iteration; next edge lo=all-ones, hi=a (raw);
//   -> IDLE; done=div_zero=1 next cycle; stall only on accept cycle.
//  Signed corners: INT_MIN magnitude = 2^(WIDTH-1) held in WIDTH bits (unsigned). INT_MIN/-1 ->
//   lo=INT_MIN, hi=0 (natural wrap, no trap). MULT INT_MIN*INT_MIN -> hi=32'h40000000, lo=0.
//  flush: any state -> IDLE next edge; hi/lo NOT modified; done=0; flush beats start same cycle.
//   Flush overrides MTHI/MTLO in same cycle.
//  Reset mid-operation: as reset; hi/lo cleared.
//  hi/lo are registered; MFHI/MFLO read them directly (no bypass of in-flight result).
// TESTING
//  1 reset: hold rst_n=0 two edges mid-BUSY -> hi=lo=0, busy=stall=0.
//  2 MULTU a=FFFFFFFF b=FFFFFFFF -> stall exactly 33 cycles; hi=FFFFFFFE lo=00000001; done 1 cycle.
//  3 MULT a=-7 b=3 -> hi=FFFFFFFF lo=FFFFFFEB; DIV a=-7 b=2 -> lo=FFFFFFFD hi=FFFFFFFF.
//  4 DIVU a=100 b=0 -> lo=FFFFFFFF hi=00000064, done&div_zero next cycle, 1 stall cycle.
//  5 DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=0; MTHI a=1234 in IDLE -> hi=1234, no stall.
//  6 MULT accepted, flush at iteration 10 -> IDLE next edge, hi/lo unchanged, no done; new start accepted.

Source files
------------

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO registers, MTHI/MTLO writes and MFHI/MFLO read-out.
// Latency: mul/div results land WIDTH+1 edges after accept (divide-by-zero after 1); MTHI/MTLO after 1 edge.
// Backpressure: stall holds IF/ID/EX from the accept cycle until HI/LO are final; start is ignored while busy.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  // MUL: {partial product high, remaining multiplier}; DIV: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Multiplicand magnitude (MUL) or divisor magnitude (DIV)
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  // neg_lo: product sign (MUL) or quotient sign (DIV); neg_hi: remainder sign (DIV only)
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  // Operand decode and magnitude extraction for the accept cycle
  logic             op_md, op_div, op_signed;
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    op_md     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    sa        = op_signed & a[WIDTH-1];
    sb        = op_signed & b[WIDTH-1];
    // INT_MIN negates to itself, which read as unsigned is the correct magnitude 2^(WIDTH-1)
    mag_a     = sa ? -a : a;
    mag_b     = sb ? -b : b;
  end

  // One radix-2 iteration: shift-add multiply or restoring divide step
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_borrow;
  logic [2*WIDTH-1:0] iter_next;
  logic               unused_diff_msb;

  always_comb begin
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    div_shift  = acc_q[2*WIDTH-1:WIDTH-1];
    div_borrow = div_shift < {1'b0, opnd_q};
    div_diff   = div_shift - {1'b0, opnd_q};
    if (is_div_q) begin
      iter_next = {(div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], ~div_borrow};
    end else begin
      iter_next = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // The remainder after a successful subtract is below the divisor, so this bit is always 0
  assign unused_diff_msb = div_diff[WIDTH];

  // Sign correction of the final iteration's result
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_lo_q ? -iter_next : iter_next;
    quo_fix  = neg_lo_q ? -iter_next[WIDTH-1:0] : iter_next[WIDTH-1:0];
    rem_fix  = neg_hi_q ? -iter_next[2*WIDTH-1:WIDTH] : iter_next[2*WIDTH-1:WIDTH];
  end

  // Next-state, iteration and HI/LO write logic; flush wins over everything
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (start && op_md) begin
        if (op_div && (b == '0)) begin
          hi_d   = a;
          lo_d   = '1;
          done_d = 1'b1;
          dz_d   = 1'b1;
        end else begin
          state_d  = BUSY;
          count_d  = '0;
          is_div_d = op_div;
          neg_lo_d = sa ^ sb;
          neg_hi_d = op_div & sa;
          if (op_div) begin
            acc_d  = {{WIDTH{1'b0}}, mag_a};
            opnd_d = mag_b;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, mag_b};
            opnd_d = mag_a;
          end
        end
      end else if (start && (op == OP_MTHI)) begin
        hi_d = a;
      end else if (start && (op == OP_MTLO)) begin
        lo_d = a;
      end
    end else begin
      acc_d   = iter_next;
      count_d = count_q + CW'(1);
      if (count_q == LAST) begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  // Outputs; stall covers the accept cycle combinationally so EX holds immediately
  always_comb begin
    hi       = hi_q;
    lo       = lo_q;
    busy     = (state_q == BUSY);
    stall    = (start && op_md && (state_q == IDLE)) || (state_q == BUSY);
    done     = done_q;
    div_zero = dz_q;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: vector table, randomized ops against an arithmetic model, and corner sequences.
// Inputs change on the falling edge; outputs are sampled 1ns after the falling edge.
// Every wait on done is bounded by a cycle budget.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, stall, done, div_zero;

  int total = 0;
  int bad   = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stl;
    logic        dz;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; division truncates toward zero like MIPS
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el,
                                output int est, output logic edz);
    longint      sx, sy, q, r;
    logic [63:0] p;
    est = 33;
    edz = 1'b0;
    eh  = '0;
    el  = '0;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    if (o == 3'd1) begin
      p = sx * sy;
      eh = p[63:32]; el = p[31:0];
    end else if (o == 3'd2) begin
      p = {32'b0, x} * {32'b0, y};
      eh = p[63:32]; el = p[31:0];
    end else if (y == 32'd0) begin
      eh = x; el = 32'hFFFF_FFFF; est = 1; edz = 1'b1;
    end else if (o == 3'd3) begin
      q = sx / sy; r = sx % sy;
      el = q[31:0]; eh = r[31:0];
    end else begin
      el = x / y; eh = x % y;
    end
  endfunction

  // Issue one mul/div and check result, stall length, done/div_zero pulse
  task automatic run_and_check(input string name, input logic [2:0] o, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                               input int est, input logic edz);
    int   stall_cnt = 0;
    int   cyc = 0;
    logic got_done = 1'b0;
    logic got_dz = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    while (cyc < 100 && !got_done) begin
      #1;
      if (stall) stall_cnt++;
      if (done) begin got_done = 1'b1; got_dz = div_zero; end
      @(negedge clk);
      start = 1'b0; op = 3'd0;
      cyc++;
    end
    check({name, " done seen"}, 64'(got_done), 64'd1);
    #1;
    check({name, " hi"}, 64'(hi), 64'(eh));
    check({name, " lo"}, 64'(lo), 64'(el));
    check({name, " stall cycles"}, 64'(stall_cnt), 64'(est));
    check({name, " div_zero"}, 64'(got_dz), 64'(edz));
    check({name, " done 1 cycle"}, 64'(done), 64'd0);
  endtask

  task automatic run_model(input string name, input logic [2:0] o, input logic [31:0] x,
                           input logic [31:0] y);
    logic [31:0] eh, el;
    int          est;
    logic        edz;
    model(o, x, y, eh, el, est, edz);
    run_and_check(name, o, x, y, eh, el, est, edz);
  endtask

  initial begin
    int done_seen;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;

    tbl[0]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0};
    tbl[1]  = '{3'd1, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b0};
    tbl[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0};
    tbl[3]  = '{3'd4, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1,  1'b1};
    tbl[4]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 1'b0};
    tbl[5]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33, 1'b0};
    tbl[6]  = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 1'b0};
    tbl[7]  = '{3'd4, 32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003, 33, 1'b0};
    tbl[8]  = '{3'd3, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1,  1'b1};
    tbl[9]  = '{3'd4, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 33, 1'b0};
    tbl[10] = '{3'd2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 33, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy/stall/done/dz", {60'd0, busy, stall, done, div_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 11; i++) begin
      run_and_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                    tbl[i].hi, tbl[i].lo, tbl[i].stl, tbl[i].dz);
    end

    // Randomized ops against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(1, 4));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 30);
      run_model($sformatf("rnd%0d", i), ro, ra, rb);
    end

    // MTHI / MTLO in IDLE: no stall, no done
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'h0000_1234;
    #1 check("mthi stall", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 32'h0000_5678;
    #1 check("mthi hi", 64'(hi), 64'h1234);
    check("mtlo stall", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    #1 check("mtlo lo", 64'(lo), 64'h5678);
    check("mthi/mtlo done", 64'(done), 64'd0);

    // Flush beats MTHI in the same cycle
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'd0; flush = 1'b0;
    #1 check("flush over mthi hi", 64'(hi), 64'h1234);

    // Flush on the accept cycle of a divide-by-zero: nothing written, no done
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'd9; b = 32'd0; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'd0; flush = 1'b0;
    #1 check("flush accept lo", 64'(lo), 64'h5678);
    check("flush accept done/busy", {62'd0, done, busy}, 64'd0);

    // MULT flushed at iteration 10: back to IDLE, hi/lo untouched, no done
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    repeat (9) @(negedge clk);
    #1 check("mid-op busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 check("flush busy", 64'(busy), 64'd0);
    check("flush stall", 64'(stall), 64'd0);
    check("flush hi/lo kept", {hi, lo}, {32'h1234, 32'h5678});
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (done) done_seen++;
    end
    check("flush no done", 64'(done_seen), 64'd0);
    check("flush hi/lo after", {hi, lo}, {32'h1234, 32'h5678});
    run_model("after flush", 3'd1, 32'd5, 32'd7);

    // Reset held two edges mid-BUSY clears everything
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'hFFFF_FFFF; b = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("midop reset hi/lo", {hi, lo}, 64'd0);
    check("midop reset busy/stall", {62'd0, busy, stall}, 64'd0);
    rst_n = 1'b1;
    run_model("after reset", 3'd3, 32'hFFFF_FF00, 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
